// File: rtl/conv1_mac_acc.sv
// rtl/conv1_mac_acc.sv - conv1 tap accumulator with bias, rounding shift, ReLU and saturation
module conv1_mac_acc #(
    parameter int PROD_W = 25,
    parameter int TAPS   = 9,
    parameter int BIAS_W = 14,
    parameter int ACC_W  = 30,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 16,
    parameter int RELU   = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [BIAS_W-1:0] bias_dat,
    input  logic [PROD_W-1:0] prod_dat,
    input  logic              prod_vld,
    output logic              prod_rdy,
    output logic [OUT_W-1:0]  res_dat,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic              busy,
    output logic              sat_flag
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);
    localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              accept;
    logic              finish;

    logic signed [ACC_W:0] bias_ext, prod_ext, acc_ext, base, sum;
    logic signed [ACC_W:0] rnd, r_sh, r_act;
    logic [OUT_W-1:0]      res_nxt;
    logic                  sat_now;

    assign prod_rdy = !(res_vld && !res_rdy);
    assign accept   = prod_vld && prod_rdy;

    assign bias_ext = {{(ACC_W+1-BIAS_W){bias_dat[BIAS_W-1]}}, bias_dat};
    assign prod_ext = {{(ACC_W+1-PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
    assign acc_ext  = {acc[ACC_W-1], acc};
    // The bias replaces the (zero) accumulator on the first tap of a window.
    assign base     = (state == S_IDLE) ? bias_ext : acc_ext;
    assign sum      = base + prod_ext;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (TAPS == 1) begin
                        finish = 1'b1;
                    end else begin
                        acc_nxt   = sum[ACC_W-1:0];
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    if (cnt == CNT_LAST) begin
                        finish    = 1'b1;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        acc_nxt = sum[ACC_W-1:0];
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            busy  <= (cnt_nxt != '0);
        end
    end

    // Round half toward +inf, then drop the fractional bits.
    assign rnd  = sum + $signed(RND);
    assign r_sh = rnd >>> SHIFT;

    always_comb begin
        r_act = r_sh;
        if (RELU != 0 && r_sh[ACC_W]) begin
            r_act = '0;
        end
        sat_now = 1'b0;
        res_nxt = r_act[OUT_W-1:0];
        if (r_act > OUT_MAX) begin
            res_nxt = OUT_MAX[OUT_W-1:0];
            sat_now = 1'b1;
        end else if (r_act < OUT_MIN) begin
            res_nxt = OUT_MIN[OUT_W-1:0];
            sat_now = 1'b1;
        end
    end

    // A finish in the same cycle as a downstream handshake reloads without a bubble.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            res_vld  <= 1'b0;
            res_dat  <= '0;
            sat_flag <= 1'b0;
        end else if (finish) begin
            res_vld  <= 1'b1;
            res_dat  <= res_nxt;
            sat_flag <= sat_flag | sat_now;
        end else if (res_vld && res_rdy) begin
            res_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv1_mac_acc.sv
// tb/tb_conv1_mac_acc.sv - directed and randomized checks of conv1_mac_acc against a reference model
module tb_conv1_mac_acc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [13:0] bias_dat;
    logic [24:0] prod_dat;
    logic        prod_vld, res_rdy;
    logic        t_vld, t_rdy;

    logic        a_prod_rdy, a_res_vld, a_busy, a_sat;
    logic [15:0] a_res_dat;
    logic        b_prod_rdy, b_res_vld, b_busy, b_sat;
    logic [15:0] b_res_dat;
    logic        t_prod_rdy, t_res_vld, t_busy, t_sat;
    logic [15:0] t_res_dat;

    conv1_mac_acc dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .bias_dat(bias_dat), .prod_dat(prod_dat),
        .prod_vld(prod_vld), .prod_rdy(a_prod_rdy), .res_dat(a_res_dat), .res_vld(a_res_vld),
        .res_rdy(res_rdy), .busy(a_busy), .sat_flag(a_sat)
    );

    conv1_mac_acc #(.RELU(0)) dut_lin (
        .ap_clk(clk), .ap_rst_n(rst_n), .bias_dat(bias_dat), .prod_dat(prod_dat),
        .prod_vld(prod_vld), .prod_rdy(b_prod_rdy), .res_dat(b_res_dat), .res_vld(b_res_vld),
        .res_rdy(res_rdy), .busy(b_busy), .sat_flag(b_sat)
    );

    conv1_mac_acc #(.TAPS(1)) dut_t1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bias_dat(bias_dat), .prod_dat(prod_dat),
        .prod_vld(t_vld), .prod_rdy(t_prod_rdy), .res_dat(t_res_dat), .res_vld(t_res_vld),
        .res_rdy(t_rdy), .busy(t_busy), .sat_flag(t_sat)
    );

    int     checks = 0;
    int     errors = 0;
    int     a_obs[$], b_obs[$], a_exp[$], b_exp[$];
    longint m_sum;
    int     m_cnt;
    bit     m_sat_a, m_sat_b;
    bit     rand_rdy;

    always @(negedge clk) begin
        if (a_res_vld && res_rdy) a_obs.push_back(int'($signed(a_res_dat)));
        if (b_res_vld && res_rdy) b_obs.push_back(int'($signed(b_res_dat)));
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_act(input longint s, input bit relu, output bit sat);
        longint r;
        r   = (s + 128) >>> 8;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r = 32767; sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; sat = 1'b1;
        end
        return int'(r);
    endfunction

    task automatic model_accept(input int b, input int p);
        bit sa, sb;
        if (m_cnt == 0) m_sum = longint'(b);
        m_sum += longint'(p);
        m_cnt++;
        if (m_cnt == 9) begin
            a_exp.push_back(ref_act(m_sum, 1'b1, sa));
            b_exp.push_back(ref_act(m_sum, 1'b0, sb));
            m_sat_a |= sa;
            m_sat_b |= sb;
            m_cnt = 0;
        end
    endtask

    task automatic push(input int b, input int p);
        bit ok;
        bias_dat = 14'(b);
        prod_dat = 25'(p);
        prod_vld = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (a_prod_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
            if (rand_rdy) res_rdy = 1'($urandom_range(0, 1));
        end
        chk("push_accepted", ok, 1);
        if (ok) model_accept(b, p);
    endtask

    task automatic idle1();
        prod_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_compare();
        int n;
        prod_vld = 1'b0;
        res_rdy  = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("a_count", a_obs.size(), a_exp.size());
        chk("b_count", b_obs.size(), b_exp.size());
        n = (a_obs.size() < a_exp.size()) ? a_obs.size() : a_exp.size();
        for (int i = 0; i < n; i++) chk("a_result", a_obs[i], a_exp[i]);
        n = (b_obs.size() < b_exp.size()) ? b_obs.size() : b_exp.size();
        for (int i = 0; i < n; i++) chk("b_result", b_obs[i], b_exp[i]);
        a_obs.delete(); b_obs.delete(); a_exp.delete(); b_exp.delete();
    endtask

    initial begin
        rst_n = 1'b0; bias_dat = '0; prod_dat = '0; prod_vld = 1'b0; res_rdy = 1'b1;
        t_vld = 1'b0; t_rdy = 1'b1; rand_rdy = 1'b0;
        m_sum = 0; m_cnt = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_res_vld", a_res_vld, 0);
        chk("rst_res_dat", a_res_dat, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_prod_rdy", a_prod_rdy, 1);
        chk("rst_t1_vld", t_res_vld, 0);
        @(posedge clk); #1;

        // nine taps of 256: one-cycle result pulse of 9
        for (int i = 0; i < 9; i++) push(0, 256);
        prod_vld = 1'b0;
        @(negedge clk);
        chk("pulse_vld", a_res_vld, 1);
        chk("pulse_dat", $signed(a_res_dat), 9);
        chk("pulse_busy", a_busy, 0);
        @(negedge clk);
        chk("pulse_end", a_res_vld, 0);
        chk("pulse_sat", a_sat, 0);
        @(posedge clk); #1;
        drain_compare();

        // negative sums: ReLU clamp vs plain rounding
        for (int i = 0; i < 9; i++) push(0, -1000);
        prod_vld = 1'b0;
        @(negedge clk);
        chk("relu_dat", $signed(a_res_dat), 0);
        chk("lin_dat", $signed(b_res_dat), -35);
        chk("relu_sat", a_sat, 0);
        chk("lin_sat", b_sat, 0);
        @(posedge clk); #1;
        drain_compare();

        // saturation and sticky flag
        for (int i = 0; i < 9; i++) push(0, 8388608);
        prod_vld = 1'b0;
        @(negedge clk);
        chk("sat_dat", $signed(a_res_dat), 32767);
        chk("sat_flag_a", a_sat, 1);
        chk("sat_flag_b", b_sat, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) push(0, 256);
        drain_compare();
        chk("sat_sticky", a_sat, 1);

        // backpressure: result held, input stalled
        res_rdy = 1'b0;
        for (int i = 0; i < 9; i++) push(0, 512);
        prod_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_prod_rdy", a_prod_rdy, 0);
            chk("bp_res_vld", a_res_vld, 1);
            chk("bp_res_dat", $signed(a_res_dat), 18);
        end
        @(posedge clk); #1;
        res_rdy = 1'b1;
        for (int i = 0; i < 9; i++) push(0, 256);
        drain_compare();

        // bias with bubbles and busy tracking
        for (int i = 0; i < 9; i++) begin
            push(127, 1);
            prod_vld = 1'b0;
            @(negedge clk);
            chk("bub_busy", a_busy, (i < 8) ? 1 : 0);
            if (i == 8) chk("bub_dat", $signed(a_res_dat), 1);
            @(posedge clk); #1;
        end
        drain_compare();

        // reset in mid-window discards partial sum
        for (int i = 0; i < 4; i++) push(0, 5000);
        prod_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cnt = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
        @(negedge clk);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_vld", a_res_vld, 0);
        chk("mrst_sat", a_sat, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) push(0, 256);
        prod_vld = 1'b0;
        @(negedge clk);
        chk("mrst_dat", $signed(a_res_dat), 9);
        @(posedge clk); #1;
        drain_compare();

        // single-tap instance: finish coincident with handshake keeps res_vld high
        bias_dat = '0;
        t_rdy = 1'b1;
        t_vld = 1'b1; prod_dat = 25'(2560);
        @(posedge clk); #1;
        prod_dat = 25'(5120);
        @(negedge clk);
        chk("t1_vld0", t_res_vld, 1);
        chk("t1_dat0", $signed(t_res_dat), 10);
        @(posedge clk); #1;
        prod_dat = 25'(7680);
        @(negedge clk);
        chk("t1_vld1", t_res_vld, 1);
        chk("t1_dat1", $signed(t_res_dat), 20);
        @(posedge clk); #1;
        t_vld = 1'b0;
        @(negedge clk);
        chk("t1_dat2", $signed(t_res_dat), 30);
        chk("t1_busy", t_busy, 0);
        @(negedge clk);
        chk("t1_vld_end", t_res_vld, 0);
        @(posedge clk); #1;

        // randomized windows with random gaps and downstream stalls
        rand_rdy = 1'b1;
        for (int w = 0; w < 8; w++) begin
            for (int t = 0; t < 9; t++) begin
                int b, p;
                b = int'($urandom_range(0, 16383)) - 8192;
                p = int'($urandom_range(0, 33554431)) - 16777216;
                if (w == 2) p = int'($urandom_range(0, 4000)) - 2000;
                push(b, p);
                if ($urandom_range(0, 2) == 0) idle1();
            end
        end
        rand_rdy = 1'b0;
        drain_compare();
        chk("rand_sat_a", a_sat, m_sat_a);
        chk("rand_sat_b", b_sat, m_sat_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1_mac_acc.md
Name: conv1_mac_acc

Overview:
- Downstream stage of the conv1 signed 10x14 -> 25-bit multiplier.
- Accumulates TAPS signed products per 3x3 output pixel, starting from a per-window bias.
- Rounds, right-shifts, applies optional ReLU and saturates to a signed OUT_W activation.
- Products arrive on a valid/ready input; results leave on a registered valid/ready output toward the pooling/line-buffer stage.

Parameters:
- PROD_W, 25, signed product width from the multiplier.
- TAPS, 9, products per output window (3x3 kernel).
- BIAS_W, 14, signed bias width, already in product scale.
- ACC_W, 30, accumulator width; must be at least PROD_W+ceil(log2(TAPS))+1.
- SHIFT, 8, fractional bits removed at output; must be at least 1.
- OUT_W, 16, signed output width.
- RELU, 1, 1 = clamp negative results to 0.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- bias_dat  in  BIAS_W  signed bias, sampled on the first accepted tap of each window.
- prod_dat  in  PROD_W  signed product.
- prod_vld  in  1  product valid.
- prod_rdy  out  1  product ready.
- res_dat  out  OUT_W  signed activation.
- res_vld  out  1  result valid.
- res_rdy  in  1  downstream ready.
- busy  out  1  high while a window is partially accumulated (cnt != 0).
- sat_flag  out  1  sticky: any result saturated since reset.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - cnt=0, acc=0, state=S_IDLE.
  - res_vld=0, res_dat=0, sat_flag=0, busy=0.
  - Reset mid-window discards the partial sum. The next accepted tap is tap 0.
- Handshake:
  - prod_rdy = !(res_vld && !res_rdy). This is combinational; input stalls only while an output is pending and not taken.
  - accept = prod_vld && prod_rdy.
  - Gaps in prod_vld are allowed; cnt and acc hold.
- State machine:
  - S_IDLE (cnt=0): on accept, acc <= sext(bias_dat) + sext(prod_dat), cnt <= 1, go to S_ACC. If TAPS=1, go straight to finish (see below).
  - S_ACC: on accept with cnt < TAPS-1, acc <= acc + sext(prod_dat), cnt <= cnt+1.
  - S_ACC: on accept with cnt = TAPS-1, finish. sum = acc + sext(prod_dat). Load the result register, cnt <= 0, acc <= 0, go to S_IDLE.
- Latency: res_vld rises the cycle after the final tap is accepted.
- Output register:
  - res_vld clears when res_vld && res_rdy, unless a finish occurs in the same cycle. In that case the new result loads and res_vld stays 1.
  - res_dat is stable while res_vld && !res_rdy.
- Arithmetic, applied to the registered result. All operations are signed at ACC_W+1 bits.
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT. Arithmetic shift, i.e. round half toward +inf.
  - If RELU=1 and r<0, then r=0.
  - If r > 2^(OUT_W-1)-1, then res_dat = 2^(OUT_W-1)-1.
  - If r < -2^(OUT_W-1), then res_dat = -2^(OUT_W-1).
  - On either clamp, sat_flag <= 1. A ReLU clamp does not set sat_flag.
  - The accumulator never wraps for legal widths, and no overflow check is applied to acc.
- busy = (cnt != 0), registered.

Test Plan:
- Defaults. bias 0, nine taps of 256 back-to-back, res_rdy=1 -> res_dat=9 one cycle after the 9th accept; res_vld is a single-cycle pulse; sat_flag=0.
- RELU=1, bias 0, nine taps of -1000 -> res_dat=0, sat_flag=0. Rerun with RELU=0 -> res_dat=-35, since (-9000+128)>>>8 = -35.
- Nine taps of 8388608 (2^23) -> r=294912, giving res_dat=32767 and sat_flag=1. sat_flag stays 1 through later normal windows until ap_rst_n=0.
- Backpressure. Complete a window with res_rdy=0 -> prod_rdy=0 and res_dat held for 5 cycles. Raise res_rdy -> the result is taken and the next 9 taps are accepted. Then fire a new finish in the same cycle as a handshake -> res_vld stays 1 with the new value.
- Bias and bubbles. bias 127, taps of 1 with prod_vld toggling every other cycle -> res_dat=1, since (136+128)>>8 = 1. busy is high from the first accept until the 9th.
- Reset mid-window. Accept 4 taps of 5000, pull ap_rst_n low for 1 cycle -> busy=0, res_vld=0. Then nine taps of 256 with bias 0 -> res_dat=9, with no contribution from the discarded taps.
